// File: rtl/axis_sram_wr_arbiter.sv
// axis_sram_wr_arbiter: round-robin packet arbiter that packs AXI-Stream beats
// into 201-bit SRAM words with per-queue write pointers, one word per 2 cycles.
module axis_sram_wr_arbiter #(
  parameter int unsigned TDATA_WIDTH     = 24,
  parameter int unsigned NUM_QUEUES      = 4,
  parameter int unsigned QUEUE_ID_WIDTH  = 2,
  parameter int unsigned QUEUE_PTR_WIDTH = 17,
  parameter int unsigned QUEUE_SIZE      = 131072
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_QUEUES*8*TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_QUEUES*TDATA_WIDTH-1:0]     s_axis_tkeep,
  input  logic [NUM_QUEUES-1:0]                 s_axis_tlast,
  input  logic [NUM_QUEUES-1:0]                 s_axis_tvalid,
  output logic [NUM_QUEUES-1:0]                 s_axis_tready,
  output logic [8*TDATA_WIDTH+8:0]              write_data,
  output logic [31:0]                           write_data_addr,
  output logic                                  write_data_valid,
  input  logic                                  write_full,
  input  logic                                  cal_done,
  output logic [NUM_QUEUES*QUEUE_PTR_WIDTH-1:0] queue_wr_ptr
);

  localparam int unsigned DATA_W = 8 * TDATA_WIDTH;
  localparam int unsigned KEEP_W = TDATA_WIDTH;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                     state, state_nxt;
  logic [QUEUE_ID_WIDTH-1:0]  grant, grant_nxt;
  logic [QUEUE_ID_WIDTH-1:0]  last_grant, last_grant_nxt;
  logic [QUEUE_ID_WIDTH-1:0]  pick;
  logic [QUEUE_PTR_WIDTH-1:0] wr_ptr [NUM_QUEUES];
  logic [DATA_W-1:0]          data_arr [NUM_QUEUES];
  logic [KEEP_W-1:0]          keep_arr [NUM_QUEUES];
  logic [DATA_W-1:0]          tdata_g;
  logic [KEEP_W-1:0]          keep_g;
  logic                       tlast_g;
  logic [7:0]                 byte_cnt;
  logic                       ready_any;
  logic                       accept;

  // Split the flat port buses into per-queue views and expose pointers.
  always_comb begin
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      data_arr[q] = s_axis_tdata[q*DATA_W +: DATA_W];
      keep_arr[q] = s_axis_tkeep[q*KEEP_W +: KEEP_W];
      queue_wr_ptr[q*QUEUE_PTR_WIDTH +: QUEUE_PTR_WIDTH] = wr_ptr[q];
    end
  end

  // Beat of the granted port and its byte count.
  always_comb begin
    tdata_g  = data_arr[grant];
    keep_g   = keep_arr[grant];
    tlast_g  = s_axis_tlast[grant];
    byte_cnt = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      byte_cnt = byte_cnt + 8'(keep_g[i]);
    end
  end

  // Round-robin search: first valid port after last_grant, with wrap.
  always_comb begin
    logic        found;
    int unsigned idx;
    found = 1'b0;
    pick  = last_grant;
    for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
      idx = (32'(last_grant) + i) % NUM_QUEUES;
      if (!found && s_axis_tvalid[QUEUE_ID_WIDTH'(idx)]) begin
        found = 1'b1;
        pick  = QUEUE_ID_WIDTH'(idx);
      end
    end
  end

  // Ready is combinational so write_full and cal_done block the same cycle;
  // gating on write_data_valid enforces the idle cycle between words.
  always_comb begin
    ready_any     = (state == XFER) && cal_done && !write_full && !write_data_valid;
    accept        = ready_any && s_axis_tvalid[grant];
    s_axis_tready = ready_any ? (NUM_QUEUES'(1) << grant) : '0;
  end

  // Next-state logic: grant in IDLE, release after an accepted tlast beat.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (cal_done && (|s_axis_tvalid)) begin
          state_nxt = XFER;
          grant_nxt = pick;
        end
      end
      XFER: begin
        if (accept && tlast_g) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Word output registers and per-queue write pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_data       <= '0;
      write_data_addr  <= '0;
      write_data_valid <= 1'b0;
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
        wr_ptr[q] <= '0;
      end
    end else begin
      write_data_valid <= accept;
      if (accept) begin
        write_data      <= {byte_cnt, tlast_g, tdata_g};
        write_data_addr <= 32'({grant, wr_ptr[grant]});
        if (wr_ptr[grant] == QUEUE_PTR_WIDTH'(QUEUE_SIZE - 1)) begin
          wr_ptr[grant] <= '0;
        end else begin
          wr_ptr[grant] <= wr_ptr[grant] + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/axis_sram_wr_arbiter.md
# axis_sram_wr_arbiter

Write-side front end of the SRAM FIFO. Accepts up to NUM_QUEUES AXI-Stream ports, arbitrates round-robin on packet boundaries, and packs each beat into one 201-bit memory word. Each word is tagged with a per-queue write address and handed to r_w_ctrl as a single-cycle `write_data_valid` pulse. It paces writes to at most one word every two cycles, matching the write-burst cadence of r_w_ctrl.

## Interface

Parameters:

- TDATA_WIDTH, 24: AXI data width in bytes (192-bit tdata).
- NUM_QUEUES, 4: number of input ports.
- QUEUE_ID_WIDTH, 2: log2(NUM_QUEUES).
- QUEUE_PTR_WIDTH, 17: per-queue word pointer width.
- QUEUE_SIZE, 131072: words per queue region; equals 2^QUEUE_PTR_WIDTH.

Ports:

- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- s_axis_tdata, in, NUM_QUEUES*8*TDATA_WIDTH: port q occupies slice q.
- s_axis_tkeep, in, NUM_QUEUES*TDATA_WIDTH: per-port byte enables.
- s_axis_tlast, in, NUM_QUEUES: end of packet, one bit per port.
- s_axis_tvalid, in, NUM_QUEUES: per-port valid.
- s_axis_tready, out, NUM_QUEUES: per-port ready; at most one bit set.
- write_data, out, 8*TDATA_WIDTH+9: packed word `{byte_cnt[7:0], tlast, tdata}`.
- write_data_addr, out, 32: `{13'b0, queue_id, wr_ptr}`.
- write_data_valid, out, 1: one-cycle pulse per word.
- write_full, in, 1: r_w_ctrl cannot accept words.
- cal_done, in, 1: SRAM calibration complete; no beat is accepted while low.
- queue_wr_ptr, out, NUM_QUEUES*QUEUE_PTR_WIDTH: next write pointer of each queue.

## Operation

- FSM states and transitions:
  - IDLE to XFER: when any `s_axis_tvalid` is high and `cal_done` is high. The grant goes to the first valid port after `last_grant`, searching upward with wrap (q = last_grant+1 … NUM_QUEUES-1, 0 … last_grant).
  - XFER: grant is held until a beat with tlast is accepted, then the FSM returns to IDLE and `last_grant` is updated to the granted port. A new grant is not decided in the same cycle as that tlast beat.
- `s_axis_tready[g] = (state==XFER) & cal_done & ~write_full & ~write_data_valid`. All other ready bits are 0.
- On a handshake of beat (tvalid & tready) on port g:
  - `write_data` is registered as `{popcount(tkeep), tlast, tdata}`. popcount ranges 0..24 and is zero-extended to 8 bits.
  - `write_data_addr` is registered as `{13'b0, g, wr_ptr[g]}`.
  - `write_data_valid` is registered high.
  - `wr_ptr[g]` increments. QUEUE_SIZE-1 wraps to 0 (natural QUEUE_PTR_WIDTH-bit rollover).
- `write_data_valid` is high for exactly one cycle. Because it gates `tready`, there is always at least one idle cycle between words.
- `write_data` and `write_data_addr` hold their last value when `write_data_valid` is low.
- No packet dropping and no occupancy check here; `write_full` from r_w_ctrl provides all backpressure. `write_full` asserts with 5 words of margin, which covers the one-word register latency.
- `cal_done` falling mid-packet stalls the packet: `tready` goes low and grant and state are kept.

## Timing

- Reset values:
  - `s_axis_tready` = 0
  - `write_data_valid` = 0
  - `write_data` = 0
  - `write_data_addr` = 0
  - all `wr_ptr` = 0
  - `last_grant` = NUM_QUEUES-1, so port 0 wins first
  - state = IDLE
- Latency: a beat accepted in cycle N produces `write_data_valid` in cycle N+1.
- Throughput: maximum one word per 2 cycles.
- Arbitration: IDLE to first `tready` takes 1 cycle. After a tlast beat, the next packet's first `tready` is no earlier than 2 cycles later.
- `write_full` sampled high in cycle N blocks any handshake in cycle N.
- Reset mid-packet: everything returns to reset values on the next edge. The partially written packet remains in SRAM but its pointer is discarded. Reset is a full flush.

## Test plan

- Single packet: port 0 sends 3 beats (tkeep all ones, last beat tkeep=0x00FFFF) after `cal_done`=1. Required:
  - three `write_data_valid` pulses, 2 cycles apart
  - addresses 0x00000, 0x00001, 0x00002
  - byte_cnt 24, 24, 16; tlast only on the third word
  - `queue_wr_ptr[0]` = 3 at the end.
- Round-robin: ports 1 and 3 each hold a 2-beat packet from reset. Required:
  - order is port 1 then port 3
  - addresses 0x20000, 0x20001, 0x60000, 0x60001
  - no interleaving within a packet.
- Wrap: preload queue 2 so `wr_ptr[2]` = 0x1FFFF (131071 words), then send a 2-beat packet. Required:
  - addresses 0x5FFFF then 0x40000
  - `queue_wr_ptr[2]` = 1.
- Backpressure: assert `write_full` after the first beat of a 4-beat packet and hold it for 10 cycles. Required:
  - `tready` = 0 and no `write_data_valid` during the hold
  - remaining 3 words emitted with correct, gap-free addresses after release.
- Calibration gate: tvalid is high on port 0 while `cal_done`=0 for 20 cycles. Required:
  - `tready` stays 0 and no output pulses
  - first `tready` appears one cycle after `cal_done` rises.
- Reset mid-packet: reset after 2 of 5 beats on port 2. Required:
  - all outputs return to their reset values
  - a following 1-beat packet on port 2 is written at 0x40000.
